// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Optional checksum stage is enabled by defining LOADER_CHECKSUM_EN.
// No logic here; consumed by instr_loader and word_assembler.
package instr_loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int LEN_MAX    = 2 ** ADDR_W_DEF;

    localparam logic [4:0] HALT_OP = 5'b00001;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// Pairs stream bytes into big-endian 16-bit words; optional XOR checksum (LOADER_CHECKSUM_EN).
// Latency: word registered on the LO byte strobe; pair is combinational {hi, current byte}.
// Backpressure: none, strobes come from the loader FSM only on accepted bytes.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        hi_en,
    input  logic        lo_en,
`ifdef LOADER_CHECKSUM_EN
    input  logic        acc_clr,
    input  logic        acc_en,
    output logic [7:0]  csum,
`endif
    output logic [15:0] pair,
    output logic [15:0] word
);

    logic [7:0] hi_q;

    assign pair = {hi_q, in_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= 8'd0;
            word <= 16'd0;
        end else begin
            if (hi_en) hi_q <= in_byte;
            if (lo_en) word <= {hi_q, in_byte};
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       csum <= 8'd0;
        else if (acc_clr) csum <= 8'd0;
        else if (acc_en)  csum <= csum ^ in_byte;
    end
`endif

endmodule

// File: rtl/instr_loader.sv
// Byte-stream loader for instruction memory: length header, N big-endian words, optional checksum (LOADER_CHECKSUM_EN).
// Latency: mem_we fires the cycle after each LO byte transfer; at least 3 cycles per word.
// Backpressure: in_ready is dropped during WRITE and outside a session; unaccepted bytes are left on the link.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_run,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [16:0]   LEN_LIM = 17'(1 << ADDR_W);
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state, state_n;
    logic [ADDR_W:0] len_q;
    logic            xfer, hi_en, lo_en, sess_clr, len_ld, len_bad;
    logic [15:0]     pair, word;
    logic [ADDR_W:0] wc_next;

    assign xfer    = in_valid & in_ready;
    assign wc_next = word_count + ONE;
    assign len_bad = (pair == 16'd0) || ({1'b0, pair} > LEN_LIM);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       acc_en;
    assign acc_en = xfer & ((state == S_DATA_HI) | (state == S_DATA_LO));

    word_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_byte (in_data),
        .hi_en   (hi_en),
        .lo_en   (lo_en),
        .acc_clr (sess_clr),
        .acc_en  (acc_en),
        .csum    (csum),
        .pair    (pair),
        .word    (word)
    );
`else
    word_assembler u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_byte (in_data),
        .hi_en   (hi_en),
        .lo_en   (lo_en),
        .pair    (pair),
        .word    (word)
    );
`endif

    assign mem_wdata = word;

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        hi_en    = 1'b0;
        lo_en    = 1'b0;
        sess_clr = 1'b0;
        len_ld   = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        cpu_run  = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                busy    = 1'b0;
                done    = (state == S_DONE);
                cpu_run = (state == S_DONE);
                err     = (state == S_ERR);
                if (start) begin
                    state_n  = S_LEN_HI;
                    sess_clr = 1'b1;
                end
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                hi_en    = xfer;
                if (xfer) state_n = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (xfer) begin
                    len_ld  = !len_bad;
                    state_n = len_bad ? S_ERR : S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                in_ready = 1'b1;
                hi_en    = xfer;
                if (xfer) state_n = S_DATA_LO;
            end
            S_DATA_LO: begin
                in_ready = 1'b1;
                lo_en    = xfer;
                if (xfer) state_n = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                state_n = (wc_next < len_q) ? S_DATA_HI : S_CSUM;
`else
                state_n = (wc_next < len_q) ? S_DATA_HI : S_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                in_ready = 1'b1;
                if (xfer) state_n = (in_data == csum) ? S_DONE : S_ERR;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    // word_count doubles as the next write address; mem_waddr keeps the last one used
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len_q      <= '0;
            word_count <= '0;
            mem_waddr  <= '0;
        end else begin
            state <= state_n;
            if (sess_clr) begin
                word_count <= '0;
                mem_waddr  <= '0;
            end
            if (len_ld)  len_q      <= pair[ADDR_W:0];
            if (lo_en)   mem_waddr  <= word_count[ADDR_W-1:0];
            if (mem_we)  word_count <= wc_next;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: normal loads, length errors, full-depth load with stalls, reset, start handling.
// Builds with or without LOADER_CHECKSUM_EN; the stream helper appends the checksum byte when enabled.
module tb_instr_loader;
    import instr_loader_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready, mem_we, busy, done, err, cpu_run;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW:0]   word_count;

    instr_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_run    (cpu_run),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int miss_cnt = 0;

    logic [15:0] mem_model [256];
    int          we_cnt = 0;
    int          rdy_viol = 0;

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            mem_model[mem_waddr] = mem_wdata;
            we_cnt++;
            if (in_ready) rdy_viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("rdy_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic settle(input string tag);
        int t;
        t = 0;
        while (busy && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    function automatic logic [15:0] pat(input int i, input logic [7:0] seed);
        logic [7:0] lo;
        lo = 8'(i * 3);
        return {8'(i) ^ seed, lo};
    endfunction

    // sends length, n words from pat(), and the checksum byte when enabled
    task automatic stream(input int n, input logic [7:0] seed, input int gapmax, input bit mid_start);
        logic [7:0]  x;
        logic [15:0] w;
        logic [15:0] nl;
        x  = 8'd0;
        nl = 16'(n);
        send_byte(nl[15:8], 0);
        send_byte(nl[7:0], 0);
        for (int i = 0; i < n; i++) begin
            if (mid_start && i == 1) pulse_start();
            w = pat(i, seed);
            send_byte(w[15:8], $urandom_range(0, gapmax));
            send_byte(w[7:0], $urandom_range(0, gapmax));
            x = x ^ w[15:8] ^ w[7:0];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, 0);
`else
        if (x == 8'hxx) $display("unreachable");
`endif
    endtask

    initial begin
        int base;
        int bad;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_run", 32'(cpu_run), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        chk("rst_addr", 32'(mem_waddr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;

        // basic two-word load
        base = we_cnt;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(negedge clk);
        chk("idle_no_rdy", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_rdy", 32'(in_ready), 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h48, 0);
        send_byte(8'h09, 0);
        send_byte(8'h08, 0);
        send_byte(8'h01, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h48 ^ 8'h09 ^ 8'h08 ^ 8'h01, 0);
`endif
        settle("t1_settle");
        chk("t1_writes", 32'(we_cnt - base), 32'd2);
        chk("t1_m0", 32'(mem_model[0]), 32'h4809);
        chk("t1_m1", 32'(mem_model[1]), 32'h0801);
        chk("t1_halt", 32'(mem_model[1][15:11]), 32'(HALT_OP));
        chk("t1_wc", 32'(word_count), 32'd2);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_run", 32'(cpu_run), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_addr_hold", 32'(mem_waddr), 32'd1);
        chk("t1_data_hold", 32'(mem_wdata), 32'h0801);

        // start in DONE clears status next cycle
        pulse_start();
        chk("redo_done", 32'(done), 32'd0);
        chk("redo_run", 32'(cpu_run), 32'd0);
        chk("redo_busy", 32'(busy), 32'd1);
        chk("redo_wc", 32'(word_count), 32'd0);

        // zero length
        base = we_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("len0_err", 32'(err), 32'd1);
        chk("len0_done", 32'(done), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_rdy", 32'(in_ready), 32'd0);
        chk("len0_run", 32'(cpu_run), 32'd0);

        // 257 is one past the memory depth
        pulse_start();
        chk("len257_clr", 32'(err), 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("len257_err", 32'(err), 32'd1);
        chk("lenerr_nowr", 32'(we_cnt - base), 32'd0);

        // full depth with random valid gaps
        base = we_cnt;
        pulse_start();
        stream(256, 8'hA5, 2, 1'b0);
        settle("full_settle");
        chk("full_writes", 32'(we_cnt - base), 32'd256);
        chk("full_wc", 32'(word_count), 32'd256);
        chk("full_last_addr", 32'(mem_waddr), 32'hFF);
        chk("full_done", 32'(done), 32'd1);
        chk("full_rdy_on_we", 32'(rdy_viol), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem_model[i] !== pat(i, 8'hA5)) bad++;
        chk("full_data", 32'(bad), 32'd0);
        chk("full_m255", 32'(mem_model[255]), 32'h5AFD);

        // reset during the third of five writes
        base = we_cnt;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hC0 + 8'(i), 0);
            send_byte(8'h10 + 8'(i), 0);
        end
        @(negedge clk);
        chk("mid_we_pre", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_we", 32'(mem_we), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rdy", 32'(in_ready), 32'd0);
        chk("mid_wc", 32'(word_count), 32'd0);
        chk("mid_addr", 32'(mem_waddr), 32'd0);
        chk("mid_writes", 32'(we_cnt - base), 32'd3);
        chk("mid_m2", 32'(mem_model[2]), 32'hC212);
        @(negedge clk) rst_n = 1'b1;

        // fresh session after reset, with a start pulse mid-stream that must be ignored
        base = we_cnt;
        pulse_start();
        stream(4, 8'h3C, 0, 1'b1);
        settle("ms_settle");
        chk("ms_writes", 32'(we_cnt - base), 32'd4);
        chk("ms_wc", 32'(word_count), 32'd4);
        chk("ms_done", 32'(done), 32'd1);
        chk("ms_m0", 32'(mem_model[0]), 32'h3C00);
        chk("ms_m3", 32'(mem_model[3]), 32'h3F09);

`ifdef LOADER_CHECKSUM_EN
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h26, 0);
        chk("cs_ok_done", 32'(done), 32'd1);
        chk("cs_ok_err", 32'(err), 32'd0);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h27, 0);
        chk("cs_bad_err", 32'(err), 32'd1);
        chk("cs_bad_run", 32'(cpu_run), 32'd0);
        chk("cs_bad_m0", 32'(mem_model[0]), 32'h1234);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Writer side of the 256x16 instruction memory. Receives a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. Writes each word through the memory's write port at incrementing addresses from 0, then releases the CPU with cpu_run. Sits between the host byte link (UART/JTAG bridge) and instruction memory.

Parameters:
ADDR_W, 8, instruction memory address width (depth 2**ADDR_W words)
DATA_W, 16, instruction word width (fixed 2 bytes per word)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse, begins a load session
in_valid  input  1  in_data holds a valid byte
in_data  input  8  stream byte
in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
mem_we  output  1  instruction memory write strobe, one cycle per word
mem_waddr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
busy  output  1  session in progress
done  output  1  session completed successfully (level, held)
err  output  1  session aborted (level, held)
cpu_run  output  1  CPU may fetch; high only in DONE
word_count  output  ADDR_W+1  words written this session

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, address counter 0, word_count 0.
- Stream format: LEN_HI, LEN_LO (N words, 16-bit big-endian), then N x (HI byte, LO byte). Valid N = 1..2**ADDR_W.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, [CSUM], DONE, ERR.
- IDLE/DONE/ERR + start -> LEN_HI. Clears done, err, cpu_run, address, word_count. start in any other state is ignored.
- in_ready = 1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM. 0 elsewhere, including WRITE.
- Each state advances only on a transfer. in_valid without in_ready is not consumed.
- LEN_LO transfer: if N==0 or N>2**ADDR_W -> ERR, else -> DATA_HI.
- DATA_LO transfer: latch {hi,lo} into mem_wdata -> WRITE.
- WRITE (1 cycle): mem_we=1, mem_waddr=current address. Next cycle address+1 and word_count+1. Then -> DATA_HI if words remain, else -> DONE (or CSUM).
- Write latency: mem_we is high the cycle after the LO byte transfer. Minimum 3 cycles per word.
- Address never wraps: N<=2**ADDR_W, so the last write is at 2**ADDR_W-1 and word_count reaches at most 2**ADDR_W.
- busy = 1 in every state except IDLE, DONE, ERR.
- DONE: done=1, cpu_run=1, held until next start or reset.
- ERR: err=1, cpu_run=0, held until next start or reset.
- Words already written before an error stay in memory. No rollback.
- Reset mid-session: immediate return to IDLE, mem_we drops asynchronously. Memory contents are whatever was already written.
- mem_waddr and mem_wdata hold their last values when mem_we=0.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: after the last WRITE -> CSUM, which accepts one byte. It must equal the XOR of all 2N data bytes (length bytes excluded). Match -> DONE; mismatch -> ERR.
- Undefined: CSUM state and the XOR accumulator are absent. Last WRITE -> DONE directly.

Decomposition:
- Package instr_loader_pkg: state encoding enum; ADDR_W/DATA_W defaults; HALT opcode constant 5'b00001 for bench checks; LEN_MAX constant.
- One natural sub-module, word_assembler: holds the hi-byte register and the optional XOR accumulator (clear/accumulate inputs), outputs the 16-bit word and the checksum.
- FSM and counters stay in instr_loader.

Test Plan:
- Reset then start; stream 00 02 48 09 08 01 -> mem_we twice: addr0=16'h4809, addr1=16'h0801; word_count=2, done=1, cpu_run=1, busy=0.
- Length 00 00 -> err=1 after LEN_LO, no mem_we. Length 01 01 (257) -> err=1, no mem_we.
- Full load N=256 with in_valid stalls (random gaps) -> 256 writes, last at addr 8'hFF, word_count=9'd256, no wrap, in_ready=0 on every WRITE cycle.
- Assert rst_n=0 after 3 of 5 words -> outputs 0 immediately, state IDLE. A new start and a full stream then completes normally.
- start pulsed while busy -> ignored, session completes unchanged. start in DONE -> done and cpu_run clear next cycle, new session begins.
- With LOADER_CHECKSUM_EN: 00 01 12 34 26 -> done. Same stream ending 27 -> err=1, addr0 still holds 16'h1234.
